// File: rtl/tdm_demux_1x8_pkg.sv
// Shared types and constants for the 1x8 TDM demultiplexer.
// FSM state encoding plus slot geometry.
package tdm_demux_1x8_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int NSLOT  = 8;
  localparam int SLOT_W = 3;

endpackage

// File: rtl/tdm_slot_cnt.sv
// Slot index counter: clear to 0, load to 1 on (re)sync,
// or advance by one with wrap at the last slot.
module tdm_slot_cnt
  import tdm_demux_1x8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_load1,
  input  logic              i_inc,
  output logic [SLOT_W-1:0] o_slot
);

  logic [SLOT_W-1:0] r_slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
    end else if (i_clr) begin
      r_slot <= '0;
    end else if (i_load1) begin
      r_slot <= SLOT_W'(1);
    end else if (i_inc) begin
      if (r_slot == SLOT_W'(NSLOT - 1))
        r_slot <= '0;
      else
        r_slot <= r_slot + SLOT_W'(1);
    end
  end

  assign o_slot = r_slot;

endmodule

// File: rtl/tdm_demux_1x8.sv
// 1-to-8 TDM demultiplexer with frame-sync lock tracking.
// Shadow collects slots 0..6; slot 7 is merged straight into Y.
module tdm_demux_1x8
  import tdm_demux_1x8_pkg::*;
#(
  parameter int MISS_LIMIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [NSLOT-1:0]  Y,
  output logic [SLOT_W-1:0] S,
  output logic              locked,
  output logic              frame_done,
  output logic              sync_err
);

  localparam int MW = $clog2(MISS_LIMIT + 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [MW-1:0]    r_miss;
  logic [MW-1:0]    w_miss_nxt;
  logic [MW-1:0]    w_miss_inc;
  logic [NSLOT-2:0] r_shadow;
  logic [NSLOT-2:0] w_shadow_nxt;
  logic [NSLOT-1:0] r_y;
  logic [NSLOT-1:0] w_y_nxt;
  logic             r_fd;
  logic             w_fd_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_clr;
  logic             w_load1;
  logic             w_inc;
  logic [SLOT_W-1:0] w_slot;
  logic             w_resync;
  logic             w_first;
  logic             w_last;
  logic             w_mid;

  tdm_slot_cnt u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_load1 (w_load1),
    .i_inc   (w_inc),
    .o_slot  (w_slot)
  );

  assign w_miss_inc = r_miss + MW'(1);
  assign w_resync   = frame_sync && (w_slot != '0);
  assign w_first    = (w_slot == '0);
  assign w_last     = !frame_sync && (w_slot == SLOT_W'(NSLOT - 1));
  assign w_mid      = !w_resync && !w_first && !w_last;

  always_comb begin
    w_state_nxt  = r_state;
    w_miss_nxt   = r_miss;
    w_shadow_nxt = r_shadow;
    w_y_nxt      = r_y;
    w_fd_nxt     = 1'b0;
    w_err_nxt    = 1'b0;
    w_clr        = 1'b0;
    w_load1      = 1'b0;
    w_inc        = 1'b0;
    if (din_valid) begin
      unique case (r_state)
        HUNT: begin
          if (frame_sync) begin
            w_shadow_nxt = {{(NSLOT-2){1'b0}}, din};
            w_load1      = 1'b1;
            w_state_nxt  = LOCKED;
            w_miss_nxt   = '0;
          end
        end
        LOCKED: begin
          unique case (1'b1)
            w_resync: begin
              w_err_nxt    = 1'b1;
              w_shadow_nxt = {{(NSLOT-2){1'b0}}, din};
              w_load1      = 1'b1;
              w_miss_nxt   = '0;
            end
            w_first: begin
              if (frame_sync) begin
                w_miss_nxt   = '0;
                w_shadow_nxt = {{(NSLOT-2){1'b0}}, din};
                w_inc        = 1'b1;
              end else begin
                w_err_nxt = 1'b1;
                // Miss limit reached: drop lock and this beat's bit
                if (w_miss_inc >= MW'(MISS_LIMIT)) begin
                  w_state_nxt = HUNT;
                  w_clr       = 1'b1;
                  w_miss_nxt  = '0;
                end else begin
                  w_miss_nxt   = w_miss_inc;
                  w_shadow_nxt = {{(NSLOT-2){1'b0}}, din};
                  w_inc        = 1'b1;
                end
              end
            end
            w_last: begin
              w_y_nxt  = {din, r_shadow};
              w_fd_nxt = 1'b1;
              w_inc    = 1'b1;
            end
            w_mid: begin
              for (int k = 1; k < NSLOT - 1; k++)
                if (w_slot == SLOT_W'(k)) w_shadow_nxt[k] = din;
              w_inc = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= HUNT;
      r_miss   <= '0;
      r_shadow <= '0;
      r_y      <= '0;
      r_fd     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_miss   <= w_miss_nxt;
      r_shadow <= w_shadow_nxt;
      r_y      <= w_y_nxt;
      r_fd     <= w_fd_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign Y          = r_y;
  assign S          = w_slot;
  assign locked     = (r_state == LOCKED);
  assign frame_done = r_fd;
  assign sync_err   = r_err;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Vector-table bench for tdm_demux_1x8 with an expectation queue.
// Expected outputs are sampled 1 time unit after each rising edge.
module tb_tdm_demux_1x8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] Y;
  logic [2:0] S;
  logic       locked;
  logic       frame_done;
  logic       sync_err;

  always #5 clk = ~clk;

  tdm_demux_1x8 #(.MISS_LIMIT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .Y          (Y),
    .S          (S),
    .locked     (locked),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  typedef struct packed {
    logic       v;
    logic       fs;
    logic       d;
    logic [7:0] y;
    logic [2:0] s;
    logic       lk;
    logic       fd;
    logic       er;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void add(logic v, logic fs, logic d, logic [7:0] y,
                              logic [2:0] s, logic lk, logic fd, logic er);
    vec_t e;
    e.v = v; e.fs = fs; e.d = d; e.y = y;
    e.s = s; e.lk = lk; e.fd = fd; e.er = er;
    tbl.push_back(e);
  endfunction

  // slots lo..hi of a locked frame; bits[k] is the slot-k bit
  function automatic void add_tail(logic [7:0] bits, logic [7:0] yprev,
                                   int lo, int hi);
    for (int k = lo; k <= hi; k++) begin
      if (k == 7) add(1, 0, bits[7], bits, 3'd0, 1, 1, 0);
      else        add(1, 0, bits[k], yprev, 3'(k + 1), 1, 0, 0);
    end
  endfunction

  task automatic chk(string name, logic [13:0] act, logic [13:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got Y=%h S=%0d lk=%b fd=%b er=%b, want Y=%h S=%0d lk=%b fd=%b er=%b",
               name, act[13:6], act[5:3], act[2], act[1], act[0],
               exp[13:6], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic run_tbl(string tag);
    vec_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      din_valid  = tbl[i].v;
      frame_sync = tbl[i].fs;
      din        = tbl[i].d;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s[%0d]: scoreboard empty", tag, i);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s[%0d]", tag, i),
            {Y, S, locked, frame_done, sync_err},
            {e.y, e.s, e.lk, e.fd, e.er});
      end
    end
    tbl.delete();
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    rst_n      = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    din        = 1'b0;
    #1;
    chk(tag, {Y, S, locked, frame_done, sync_err}, 14'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    din        = 1'b0;
    do_reset("reset");

    // basic frame, then a frame with a 3-cycle stall after slot 3
    add(1, 1, 1, 8'h00, 3'd1, 1, 0, 0);
    add_tail(8'hB5, 8'h00, 1, 7);
    add(0, 0, 0, 8'hB5, 3'd0, 1, 0, 0);
    add(1, 1, 1, 8'hB5, 3'd1, 1, 0, 0);
    add_tail(8'hB5, 8'hB5, 1, 3);
    repeat (3) add(0, 1, 1, 8'hB5, 3'd4, 1, 0, 0);
    add_tail(8'hB5, 8'hB5, 4, 7);
    // early frame_sync at S=5, then a full frame from the resync
    add(1, 1, 0, 8'hB5, 3'd1, 1, 0, 0);
    add_tail(8'h1E, 8'hB5, 1, 4);
    add(1, 1, 1, 8'hB5, 3'd1, 1, 0, 1);
    add_tail(8'h81, 8'hB5, 1, 7);
    add(0, 0, 0, 8'h81, 3'd0, 1, 0, 0);
    // two missing syncs at slot 0 -> lock lost
    add(1, 0, 1, 8'h81, 3'd1, 1, 0, 1);
    add_tail(8'h81, 8'h81, 1, 7);
    add(1, 0, 0, 8'h81, 3'd0, 0, 0, 1);
    add(1, 0, 1, 8'h81, 3'd0, 0, 0, 0);
    add(1, 0, 0, 8'h81, 3'd0, 0, 0, 0);
    // relock and advance to S=4
    add(1, 1, 1, 8'h81, 3'd1, 1, 0, 0);
    add_tail(8'hFF, 8'h81, 1, 3);
    run_tbl("seq");

    // asynchronous reset mid-frame
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    din_valid = 1'b0;
    #1;
    chk("async_rst", {Y, S, locked, frame_done, sync_err}, 14'h0);
    @(negedge clk);
    rst_n = 1'b1;
    add(0, 0, 0, 8'h00, 3'd0, 0, 0, 0);
    add(1, 0, 1, 8'h00, 3'd0, 0, 0, 0);
    add(1, 0, 1, 8'h00, 3'd0, 0, 0, 0);
    add(1, 1, 0, 8'h00, 3'd1, 1, 0, 0);
    add_tail(8'hFE, 8'h00, 1, 7);
    run_tbl("post_rst");

    // HUNT with random data and no sync
    do_reset("reset2");
    for (int i = 0; i < 20; i++)
      add(1, 0, 1'($urandom_range(0, 1)), 8'h00, 3'd0, 0, 0, 0);
    // frame_sync at S=7 is a resync, not a completion
    add(1, 1, 1, 8'h00, 3'd1, 1, 0, 0);
    add_tail(8'h7E, 8'h00, 1, 6);
    add(1, 1, 0, 8'h00, 3'd1, 1, 0, 1);
    add(0, 0, 0, 8'h00, 3'd1, 1, 0, 0);
    run_tbl("hunt");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
